// File: rtl/reg_file.sv
// Integer/floating register file with PC register and a latency-1 triple-operand read port.
// Optional REG_FILE_BYPASS_EN forwards same-edge write data to matching reads.
module reg_file #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pcenable,
  input  logic [31:0] next_pc,
  input  logic        wenable,
  input  logic        fmode,
  input  logic [4:0]  wreg,
  input  logic [31:0] wdata,
  input  logic        enable,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rs3,
  input  logic [2:0]  fsel,
  output logic        done,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [31:0] data3,
  output logic [31:0] pc
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned NOPER = 3;

  logic [XLEN-1:0] x_q    [NREG];
  logic [XLEN-1:0] x_d    [NREG];
  logic [XLEN-1:0] f_q    [NREG];
  logic [XLEN-1:0] f_d    [NREG];
  logic [XLEN-1:0] data_q [NOPER];
  logic [XLEN-1:0] data_d [NOPER];
  logic [XLEN-1:0] pc_q, pc_d;
  logic            done_q, done_d;
  logic [4:0]      rs_idx [NOPER];

  assign rs_idx[0] = rs1;
  assign rs_idx[1] = rs2;
  assign rs_idx[2] = rs3;

  // Write port, PC update and read port; reads see pre-edge contents unless bypassed.
  always_comb begin
    x_d    = x_q;
    f_d    = f_q;
    data_d = data_q;
    pc_d   = pc_q;
    done_d = 1'b0;

    if (wenable) begin
      if (fmode) f_d[wreg] = wdata;
      else if (wreg != 5'd0) x_d[wreg] = wdata;
    end
    x_d[0] = '0;

    if (pcenable) pc_d = next_pc;

    if (enable) begin
      done_d = 1'b1;
      for (int i = 0; i < NOPER; i++) begin
        if (fsel[i]) data_d[i] = f_q[rs_idx[i]];
        else if (rs_idx[i] == 5'd0) data_d[i] = '0;
        else data_d[i] = x_q[rs_idx[i]];
`ifdef REG_FILE_BYPASS_EN
        // x0 never forwards: its write is discarded.
        if (wenable && (fsel[i] == fmode) && (rs_idx[i] == wreg) &&
            !(!fmode && (wreg == 5'd0)))
          data_d[i] = wdata;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) begin
        x_q[i] <= '0;
        f_q[i] <= '0;
      end
      for (int i = 0; i < NOPER; i++) data_q[i] <= '0;
      pc_q   <= RESET_PC;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      f_q    <= f_d;
      data_q <= data_d;
      pc_q   <= pc_d;
      done_q <= done_d;
    end
  end

  assign done  = done_q;
  assign data1 = data_q[0];
  assign data2 = data_q[1];
  assign data3 = data_q[2];
  assign pc    = pc_q;

endmodule
